// File: rtl/pll_pkg.sv
// Shared constants for the ring-oscillator PLL loop controller.
package pll_pkg;
  localparam int DIV_W    = 5;
  localparam int CNT_W    = 6;
  localparam int TVAL_W   = 7;
  localparam int TRIM_W   = 26;
  localparam int TVAL_MAX = 127;
  localparam int CNT_MAX  = 63;
endpackage

// File: rtl/pll_controller_osc_edge_sync.sv
// Brings the free-running oscillator into the reference clock domain and
// emits a registered one-cycle pulse per rising edge.
module osc_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic osc,
  output logic edge_pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic sync_prev_q, sync_prev_d;
  logic edge_q, edge_d;

  always_comb begin
    meta_d      = osc;
    sync_d      = meta_q;
    sync_prev_d = sync_q;
    edge_d      = sync_q & ~sync_prev_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q      <= 1'b0;
      sync_q      <= 1'b0;
      sync_prev_q <= 1'b0;
      edge_q      <= 1'b0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      sync_prev_q <= sync_prev_d;
      edge_q      <= edge_d;
    end
  end

  assign edge_pulse = edge_q;

endmodule

// File: rtl/pll_controller.sv
// Measures the oscillator period in reference clocks, nudges the trim
// accumulator toward the target ratio and drives a thermometer trim bus.
module pll_controller #(
  parameter int DIV_W  = pll_pkg::DIV_W,
  parameter int CNT_W  = pll_pkg::CNT_W,
  parameter int TVAL_W = pll_pkg::TVAL_W,
  parameter int TRIM_W = pll_pkg::TRIM_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              osc,
  input  logic [DIV_W-1:0]  div,
  output logic [TRIM_W-1:0] trim
);

  localparam int TINT_W = TVAL_W - 2;
  localparam logic [CNT_W-1:0]  CNT_SAT  = '1;
  localparam logic [TVAL_W-1:0] TVAL_SAT = '1;

  logic              edge_pulse;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W:0]    period_q, period_d;
  logic              valid_q, valid_d;
  logic [TVAL_W-1:0] tval, tval_d;
  logic [TRIM_W-1:0] trim_q, trim_d;
  logic [CNT_W:0]    meas;
  logic [CNT_W:0]    div_ext;
  logic [TINT_W-1:0] tint;

  osc_edge_sync u_sync (
    .clock      (clock),
    .reset      (reset),
    .osc        (osc),
    .edge_pulse (edge_pulse)
  );

  // One extra bit so a saturated count of 63 still reads as 64 clocks.
  assign meas    = {1'b0, cnt_q} + 1'b1;
  assign div_ext = {{(CNT_W + 1 - DIV_W){1'b0}}, div};
  assign tint    = tval[TVAL_W-1:2];

  always_comb begin
    cnt_d    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    period_d = period_q;
    valid_d  = valid_q;
    tval_d   = tval;
    if (edge_pulse) begin
      cnt_d    = '0;
      period_d = meas;
      valid_d  = 1'b1;
      // div of zero parks the loop; the first edge only opens a window.
      if (valid_q && (div != '0)) begin
        if ((meas > div_ext) && (tval != TVAL_SAT)) begin
          tval_d = tval + 1'b1;
        end else if ((meas < div_ext) && (tval != '0)) begin
          tval_d = tval - 1'b1;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < TRIM_W; gi++) begin : g_therm
      assign trim_d[gi] = (32'(tint) > gi);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      tval     <= '0;
      trim_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      tval     <= tval_d;
      trim_q   <= trim_d;
    end
  end

  assign trim = trim_q;

endmodule

// File: tb/tb_pll_controller.sv
// Randomized scoreboard bench for pll_controller: a period/step model predicts
// the trim value after every oscillator edge and a monitor checks it.
module tb_pll_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        osc   = 1'b0;
  logic [4:0]  div   = 5'd8;
  logic [25:0] trim;

  pll_controller dut (
    .clock (clock),
    .reset (reset),
    .osc   (osc),
    .div   (div),
    .trim  (trim)
  );

  always #5 clock = ~clock;

  typedef struct {
    int due_pre;
    int due_post;
    int old_t;
    int new_t;
    bit pre_done;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  int   m_tval   = 0;
  bit   m_valid  = 1'b0;
  int   m_last   = 0;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  function automatic logic [25:0] therm(input int t);
    int n;
    logic [31:0] v;
    n = t / 4;
    if (n > 26) n = 26;
    v = (32'd1 << n) - 32'd1;
    return v[25:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, req);
    end
  endtask

  // Monitor: the edge pipeline is fixed-latency, so each entry is due at a known cycle.
  initial forever begin
    @(negedge clock);
    if (sb.size() > 0) begin
      if (!sb[0].pre_done && cyc >= sb[0].due_pre) begin
        check("tval_before", 32'(dut.tval), 32'(sb[0].old_t));
        check("trim_before", 32'(trim), 32'(therm(sb[0].old_t)));
        sb[0].pre_done = 1'b1;
      end
      if (cyc >= sb[0].due_post) begin
        check("tval_after", 32'(dut.tval), 32'(sb[0].new_t));
        check("trim_after", 32'(trim), 32'(therm(sb[0].new_t)));
        $display("edge cycle=%0d div=%0d tval=%0d expected=%0d trim=%07h",
                 cyc, div, dut.tval, sb[0].new_t, trim);
        void'(sb.pop_front());
      end
    end
  end

  // One oscillator period of p clocks with target d; called on a falling clock edge.
  task automatic osc_edge(input int p, input int d);
    int c, per, nt;
    c   = cyc;
    div = 5'(d);
    nt  = m_tval;
    if (m_valid) begin
      per = c - m_last;
      if (per > 64) per = 64;
      if (d != 0) begin
        if (per > d && nt < 127) nt++;
        else if (per < d && nt > 0) nt--;
      end
    end
    m_valid = 1'b1;
    m_last  = c;
    sb.push_back('{c + 3, c + 5, m_tval, nt, 1'b0});
    m_tval = nt;
    osc = 1'b1;
    repeat (p / 2) @(negedge clock);
    osc = 1'b0;
    repeat (p - p / 2) @(negedge clock);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout cycle=%0d pending=%0d required=0", cyc, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    drain();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset   = 1'b0;
    m_tval  = 0;
    m_valid = 1'b0;
    check("reset_tval", 32'(dut.tval), 32'd0);
    check("reset_trim", 32'(trim), 32'd0);
    @(negedge clock);
  endtask

  initial begin
    int r, p;
    @(negedge clock);
    do_reset();
    // Matched ratio: nothing moves.
    repeat (8) osc_edge(8, 8);
    // Slow oscillator relative to target: climb.
    repeat (10) osc_edge(8, 5);
    // Fast oscillator: descend to zero and stay there.
    repeat (14) osc_edge(8, 20);
    // Push to the top and hold at saturation.
    repeat (140) osc_edge($urandom_range(4, 9), 1);
    // Loop disabled.
    repeat (10) osc_edge($urandom_range(4, 30), 0);
    // Random ratios, including stalled-oscillator periods that saturate the counter.
    repeat (200) begin
      r = $urandom_range(0, 9);
      p = (r == 0) ? $urandom_range(60, 80) : $urandom_range(4, 40);
      osc_edge(p, $urandom_range(0, 31));
    end
    // Reset in the middle of a measurement; the first edge afterwards must not step.
    repeat (6) osc_edge(8, 1);
    do_reset();
    repeat (6) osc_edge(8, 1);
    repeat (60) osc_edge($urandom_range(4, 24), $urandom_range(0, 12));
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
